// File: rtl/bin_enc_drain_if.sv
// ============================================================================
// Module   : bin_enc_drain_if
// Brief    : Handshake bundle for bin_enc_drain (vector in, index stream out).
//            Carries cnt only when BIN_ENC_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

interface bin_enc_drain_if #(
  parameter int OUT = 3
);
  localparam int IN = 1 << OUT;

  logic          in_valid;
  logic          in_ready;
  logic [IN-1:0] in;
  logic          out_valid;
  logic          out_ready;
  logic [OUT-1:0] out;
  logic          out_last;
  logic          busy;
`ifdef BIN_ENC_CNT_EN
  logic [OUT:0]  cnt;
`endif

  modport master (
    output in_valid, in, out_ready,
`ifdef BIN_ENC_CNT_EN
    input  cnt,
`endif
    input  in_ready, out_valid, out, out_last, busy
  );

  modport slave (
    input  in_valid, in, out_ready,
`ifdef BIN_ENC_CNT_EN
    output cnt,
`endif
    output in_ready, out_valid, out, out_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/bin_enc_drain.sv
// ============================================================================
// Module   : bin_enc_drain
// Brief    : Sequential encoder; drains a multi-hot vector as a stream of
//            indices, lowest first. Optional macro BIN_ENC_CNT_EN adds cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_enc_drain #(
  parameter int   OUT = 3,
  parameter logic ACT = `HIGH
) (
  input  logic             clk,
  input  logic             reset_,
  bin_enc_drain_if.slave   bus
);
  localparam int IN = 1 << OUT;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IN-1:0]  r_pending;
  logic [IN-1:0]  w_pending_nxt;
  logic [IN-1:0]  w_mask;
  logic [IN-1:0]  w_rest;
  logic [OUT-1:0] w_low_idx;
  logic           w_drain;
  logic           w_last;
  logic           w_beat;
  logic           w_load;
  logic           w_in_ready;

  assign w_mask  = bus.in ^ {IN{~ACT}};
  assign w_drain = (r_state == ST_DRAIN);
  // Clearing the lowest set bit leaves what remains after this beat.
  assign w_rest  = r_pending & (r_pending - IN'(1));
  assign w_last  = (r_pending != '0) && (w_rest == '0);

  always_comb begin
    w_low_idx = '0;
    for (int i = IN - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_idx = OUT'(i);
      end
    end
  end

  assign w_beat     = w_drain & bus.out_ready;
  assign w_in_ready = ~w_drain | (w_beat & w_last);
  assign w_load     = bus.in_valid & w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_drain;
  assign bus.out       = w_drain ? w_low_idx : '0;
  assign bus.out_last  = w_drain & w_last;
  assign bus.busy      = w_drain;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    if (w_beat) begin
      w_pending_nxt = w_rest;
      if (w_last) begin
        w_state_nxt = ST_IDLE;
      end
    end
    // A load overrides the final beat's update for back-to-back vectors.
    if (w_load) begin
      if (w_mask != '0) begin
        w_pending_nxt = w_mask;
        w_state_nxt   = ST_DRAIN;
      end else begin
        w_pending_nxt = '0;
        w_state_nxt   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

`ifdef BIN_ENC_CNT_EN
  logic [OUT:0] r_cnt;

  function automatic logic [OUT:0] popcount(input logic [IN-1:0] v);
    logic [OUT:0] n;
    n = '0;
    for (int i = 0; i < IN; i++) begin
      n = n + (OUT+1)'(v[i]);
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= popcount(w_mask);
    end else if (w_beat) begin
      r_cnt <= r_cnt - (OUT+1)'(1);
    end
  end

  assign bus.cnt = r_cnt;
`endif

endmodule

`default_nettype wire
